// File: rtl/cdu_count_link.sv
// cdu_count_link
// Accumulates the CDU's +/- angle-increment pulses into a signed pending count
// and drains that count to the AGC. Each count is sent as one up or down
// request over a request/acknowledge handshake. After every acknowledged
// request a fixed idle gap is enforced, so the AGC counter cells are never
// driven faster than they can count.
module cdu_count_link #(
    parameter int PEND_W  = 6,
    parameter int MIN_GAP = 4
) (
    input  logic              CLOCKH,
    input  logic              rst,
    input  logic              PLSP,
    input  logic              PLSM,
    input  logic              CLRH,
    input  logic              ACKH,
    output logic              INCRH,
    output logic              DECRH,
    output logic [PEND_W-1:0] PEND,
    output logic              OVFH,
    output logic              BUSYH
);

    // Two guard bits let the saturation test see a pulse and an ack landing
    // together without wrapping.
    localparam int SUM_W = PEND_W + 2;
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    localparam logic signed [SUM_W-1:0] PEND_MAX = SUM_W'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] PEND_MIN = SUM_W'(-(1 << (PEND_W - 1)));

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    // Clamp a wide sum into the pending range. The MSB of the result flags
    // that clamping happened.
    function automatic logic [PEND_W:0] saturate(input logic signed [SUM_W-1:0] value);
        logic [PEND_W:0] result;
        if (value > PEND_MAX) begin
            result = {1'b1, PEND_MAX[PEND_W-1:0]};
        end else if (value < PEND_MIN) begin
            result = {1'b1, PEND_MIN[PEND_W-1:0]};
        end else begin
            result = {1'b0, value[PEND_W-1:0]};
        end
        return result;
    endfunction

    state_t                    state_r;
    state_t                    state_nx_s;
    logic                      incr_r;
    logic                      incr_nx_s;
    logic                      decr_r;
    logic                      decr_nx_s;
    logic signed [PEND_W-1:0]  pend_r;
    logic signed [PEND_W-1:0]  pend_nx_s;
    logic                      ovf_r;
    logic                      ovf_nx_s;
    logic                      cancel_r;
    logic                      cancel_nx_s;
    logic [GAP_W-1:0]          gap_r;
    logic [GAP_W-1:0]          gap_nx_s;
    logic                      busy_r;

    logic                      pend_pos_s;
    logic                      pend_neg_s;
    logic                      ack_taken_s;
    logic signed [SUM_W-1:0]   pls_step_s;
    logic signed [SUM_W-1:0]   ack_step_s;
    logic signed [SUM_W-1:0]   sum_s;
    logic [PEND_W:0]           sat_s;

    // Sign of the registered pending count; the FSM decides on these alone.
    always_comb begin
        pend_neg_s = pend_r[PEND_W-1];
        pend_pos_s = !pend_r[PEND_W-1] && (pend_r != {PEND_W{1'b0}});
    end

    // Net step from the pulses and from a consumed ack, and the clamped new count.
    always_comb begin
        ack_taken_s = (state_r == ST_REQ) && ACKH && !cancel_r;

        case ({PLSP, PLSM})
            2'b10:   pls_step_s = {{(SUM_W-1){1'b0}}, 1'b1};
            2'b01:   pls_step_s = {SUM_W{1'b1}};
            default: pls_step_s = {SUM_W{1'b0}};
        endcase

        // The ack retires one count in the direction latched at issue.
        if (!ack_taken_s) begin
            ack_step_s = {SUM_W{1'b0}};
        end else if (incr_r) begin
            ack_step_s = {SUM_W{1'b1}};
        end else begin
            ack_step_s = {{(SUM_W-1){1'b0}}, 1'b1};
        end

        sum_s = SUM_W'(pend_r) + pls_step_s + ack_step_s;
        sat_s = saturate(sum_s);

        // Clear wins over pulses and the ack adjustment.
        if (CLRH) begin
            pend_nx_s = {PEND_W{1'b0}};
            ovf_nx_s  = 1'b0;
        end else begin
            pend_nx_s = sat_s[PEND_W-1:0];
            ovf_nx_s  = ovf_r | sat_s[PEND_W];
        end
    end

    // Request FSM: next state, request lines, gap counter and cancel flag.
    always_comb begin
        state_nx_s  = state_r;
        incr_nx_s   = incr_r;
        decr_nx_s   = decr_r;
        gap_nx_s    = gap_r;
        cancel_nx_s = cancel_r;

        case (state_r)
            ST_IDLE: begin
                if (pend_pos_s) begin
                    incr_nx_s  = 1'b1;
                    decr_nx_s  = 1'b0;
                    state_nx_s = ST_REQ;
                end else if (pend_neg_s) begin
                    incr_nx_s  = 1'b0;
                    decr_nx_s  = 1'b1;
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The request is held until the AGC takes it, whatever PEND does.
                if (ACKH) begin
                    incr_nx_s   = 1'b0;
                    decr_nx_s   = 1'b0;
                    gap_nx_s    = GAP_W'(MIN_GAP);
                    cancel_nx_s = 1'b0;
                    state_nx_s  = ST_GAP;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_GAP: begin
                if (gap_r <= GAP_W'(1)) begin
                    gap_nx_s   = {GAP_W{1'b0}};
                    state_nx_s = ST_IDLE;
                end else begin
                    gap_nx_s   = gap_r - GAP_W'(1);
                    state_nx_s = ST_GAP;
                end
            end
            default: begin
                incr_nx_s   = 1'b0;
                decr_nx_s   = 1'b0;
                gap_nx_s    = {GAP_W{1'b0}};
                cancel_nx_s = 1'b0;
                state_nx_s  = ST_IDLE;
            end
        endcase

        // A clear while a request is outstanding (or just being raised)
        // makes its eventual ack a no-op on PEND.
        if (CLRH && (state_nx_s == ST_REQ)) begin
            cancel_nx_s = 1'b1;
        end else begin
            cancel_nx_s = cancel_nx_s;
        end
    end

    // State and output registers; reset drops any request immediately.
    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            incr_r   <= 1'b0;
            decr_r   <= 1'b0;
            pend_r   <= {PEND_W{1'b0}};
            ovf_r    <= 1'b0;
            cancel_r <= 1'b0;
            gap_r    <= {GAP_W{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            incr_r   <= incr_nx_s;
            decr_r   <= decr_nx_s;
            pend_r   <= pend_nx_s;
            ovf_r    <= ovf_nx_s;
            cancel_r <= cancel_nx_s;
            gap_r    <= gap_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    assign INCRH = incr_r;
    assign DECRH = decr_r;
    assign PEND  = pend_r;
    assign OVFH  = ovf_r;
    assign BUSYH = busy_r;

    cdu_count_link_chk u_chk (
        .clk  (CLOCKH),
        .rst  (rst),
        .incr (incr_r),
        .decr (decr_r),
        .ack  (ACKH),
        .busy (busy_r)
    );

endmodule

// Handshake invariants of the count link.
module cdu_count_link_chk (
    input logic clk,
    input logic rst,
    input logic incr,
    input logic decr,
    input logic ack,
    input logic busy
);

    // Never request both directions at once.
    a_onehot: assert property (@(posedge clk) disable iff (rst) !(incr && decr));

    // An un-acknowledged up request stays up.
    a_incr_hold: assert property (@(posedge clk) disable iff (rst) (incr && !ack) |=> incr);

    // An un-acknowledged down request stays up.
    a_decr_hold: assert property (@(posedge clk) disable iff (rst) (decr && !ack) |=> decr);

    // A visible request always means the link reports busy.
    a_busy: assert property (@(posedge clk) disable iff (rst) (incr || decr) |-> busy);

endmodule
